line_req_arbiter: RTL
=====================

Name: line_req_arbiter

Overview:
- Two-master arbiter directly upstream of the cache-line AXI burst adapter.
- Merges the instruction-cache refill port (read only) and the data-cache port (refill read plus dirty-line write-back) onto the adapter's single line-request interface.
- Holds the winning master's request, address and write line stable until the adapter pulses gnt, then returns that gnt to the winner only.
- Round-robin between masters; each grant covers one whole line transfer.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; LINE_WORDS = 1<<LINE_ADDR_LEN; must equal the adapter's value.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active high
- i_addr  in  32  icache line address
- i_rd_req  in  1  icache refill request; level, held until i_gnt
- i_gnt  out  1  one-cycle pulse, icache transfer complete
- d_addr  in  32  dcache line address
- d_rd_req  in  1  dcache refill request; level, held until d_gnt
- d_wr_req  in  1  dcache write-back request; level, held until d_gnt
- d_wr_line  in  32 x LINE_WORDS  dcache write line; stable while d_wr_req
- d_gnt  out  1  one-cycle pulse, dcache transfer complete
- rd_line  out  32 x LINE_WORDS  adapter read line, broadcast to both masters
- m_gnt  in  1  adapter completion pulse
- m_addr  out  32  to adapter
- m_rd_req  out  1  to adapter
- m_wr_req  out  1  to adapter
- m_wr_line  out  32 x LINE_WORDS  to adapter
- m_rd_line  in  32 x LINE_WORDS  from adapter

Behaviour:
- States (registered): IDLE, OWN_I, OWN_D. Register last_d records whether the dcache was served last.
- Reset (areset=1, any cycle, asynchronous): state=IDLE, last_d=0.
  - All outputs read 0 while in IDLE: m_rd_req, m_wr_req, m_addr, m_wr_line, i_gnt, d_gnt.
  - rd_line mirrors m_rd_line in every state.
- Arbitration in IDLE, evaluated on registered inputs:
  - reqI = i_rd_req; reqD = d_rd_req | d_wr_req.
  - Only reqD: go to OWN_D. Only reqI: go to OWN_I.
  - Both: if last_d=1 go to OWN_I, else go to OWN_D. After reset, dcache wins the first tie.
  - Neither: stay in IDLE.
  - IDLE forwards nothing. Latency is one cycle from a master's request to the m_*_req assertion.
- OWN_I:
  - m_addr=i_addr, m_rd_req=i_rd_req, m_wr_req=0, m_wr_line=0.
  - i_gnt=m_gnt (combinational), d_gnt=0.
  - On m_gnt=1: go to IDLE, last_d<=0.
- OWN_D:
  - m_addr=d_addr, m_rd_req=d_rd_req, m_wr_req=d_wr_req, m_wr_line=d_wr_line.
  - d_gnt=m_gnt (combinational), i_gnt=0.
  - Both d_rd_req and d_wr_req high: both are forwarded; the adapter treats the request as a write.
  - On m_gnt=1: go to IDLE, last_d<=1.
- The lock holds until m_gnt, even if the owner drops its request early (protocol violation). The transfer in flight completes and gnt still goes to the owner.
- m_gnt while in IDLE is ignored: no gnt to any master, no state change.
- Cycle after a gnt:
  - The arbiter is in IDLE, so m_*_req=0 and the adapter cannot restart on a stale request.
  - The master must have dropped its request by then. If it has not, that request is re-arbitrated as a new request.
- Back-to-back: the minimum gap between consecutive m_*_req assertions is one IDLE cycle.
- No combinational path from any request input to m_*_req within IDLE. gnt outputs are combinational from m_gnt.

Decomposition:
- Shared package cache_axi_pkg holds:
  - LINE_ADDR_LEN default;
  - line_t (array of LINE_WORDS 32-bit words);
  - arb_state_t enum {IDLE, OWN_I, OWN_D}.
- No sub-module. A single module with one state register block and one combinational output mux.

Test Plan:
- Single icache read: i_rd_req=1, i_addr=0x1FC0_0020. Expect m_rd_req=1 and m_addr=0x1FC0_0020 one cycle later. Drive m_gnt high for one cycle → i_gnt pulses 1 in that cycle, d_gnt stays 0, state returns to IDLE.
- Dcache write-back: d_wr_req=1, d_addr=0x8000_0100, d_wr_line words 0x0..0x7. Expect m_wr_req=1, m_rd_req=0 and m_wr_line equal to the input until m_gnt; then d_gnt=1.
- Tie after reset: i_rd_req and d_rd_req rise together. Expect OWN_D first and d_gnt first. icache is held until it is served next, with exactly one IDLE cycle between the two grants.
- Round-robin fairness: both masters request continuously for 6 transfers. Expect the grant order D,I,D,I,D,I; neither master is starved.
- Early drop and spurious gnt:
  - d_rd_req falls mid-transfer → m_addr still tracks d_addr and d_gnt still pulses on m_gnt.
  - m_gnt asserted in IDLE → no gnt output and no state change.
- Asynchronous reset during OWN_I: areset pulse between clock edges → m_rd_req=0 immediately (before the next edge), state=IDLE, and the next tie goes to the dcache.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache-line request path: line geometry,
// the line data type and the arbiter state encoding.
package cache_axi_pkg;

  localparam int LINE_ADDR_LEN = 3;
  localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/line_req_arbiter_if.sv
// Line-request port: a requester (master) presents address, read/write request
// and write line; the responder (slave) returns a completion pulse and read line.
interface line_req_if #(
  parameter int LINE_ADDR_LEN = cache_axi_pkg::LINE_ADDR_LEN
);

  logic [31:0]                             addr;
  logic                                    rd_req;
  logic                                    wr_req;
  logic [(1 << LINE_ADDR_LEN)-1:0][31:0]   wr_line;
  logic                                    gnt;
  logic [(1 << LINE_ADDR_LEN)-1:0][31:0]   rd_line;

  modport master (
    output addr, rd_req, wr_req, wr_line,
    input  gnt, rd_line
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_line,
    output gnt, rd_line
  );

endinterface

// File: rtl/line_req_arbiter.sv
// Round-robin arbiter merging the icache refill port and the dcache port onto
// the single line-request interface of the AXI burst adapter.
module line_req_arbiter #(
  parameter int LINE_ADDR_LEN = cache_axi_pkg::LINE_ADDR_LEN
) (
  input  logic       aclk,
  input  logic       areset,
  line_req_if.slave  i_port,
  line_req_if.slave  d_port,
  line_req_if.master m_port
);

  import cache_axi_pkg::*;

  arb_state_t state_q, state_d;
  logic       last_d_q, last_d_d;
  logic       req_i_s, req_d_s;

  assign req_i_s = i_port.rd_req;
  assign req_d_s = d_port.rd_req | d_port.wr_req;

  assign i_port.rd_line = m_port.rd_line;
  assign d_port.rd_line = m_port.rd_line;

  // Ownership and fairness registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Arbitration and the owner-selected output mux; IDLE forwards nothing.
  always_comb begin
    state_d        = state_q;
    last_d_d       = last_d_q;
    m_port.addr    = 32'h0000_0000;
    m_port.rd_req  = 1'b0;
    m_port.wr_req  = 1'b0;
    m_port.wr_line = '0;
    i_port.gnt     = 1'b0;
    d_port.gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_d_s && (!req_i_s || !last_d_q)) begin
          state_d = OWN_D;
        end else if (req_i_s) begin
          state_d = OWN_I;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_I: begin
        m_port.addr   = i_port.addr;
        m_port.rd_req = i_port.rd_req;
        i_port.gnt    = m_port.gnt;
        // Lock holds until completion even if the owner drops its request.
        if (m_port.gnt) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end else begin
          state_d  = OWN_I;
        end
      end
      OWN_D: begin
        m_port.addr    = d_port.addr;
        m_port.rd_req  = d_port.rd_req;
        m_port.wr_req  = d_port.wr_req;
        m_port.wr_line = d_port.wr_line;
        d_port.gnt     = m_port.gnt;
        if (m_port.gnt) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end else begin
          state_d  = OWN_D;
        end
      end
      default: begin
        state_d  = IDLE;
        last_d_d = 1'b0;
      end
    endcase
  end

endmodule
